mul_hilo_unit: RTL and testbench
================================

# mul_hilo_unit

Multicycle wrapper around the combinational radix-4 Booth multiplier `booth_mul`. It sits between the register file/ALU operand path and the HI/LO register pair. It latches operands, gives the combinational product a fixed number of clock cycles to settle, then captures the 64-bit result into HI/LO with a busy/done handshake. It also owns the HI/LO registers themselves, including the direct-load (move-to-HI/LO) path.

## Interface
- `SETTLE_CYCLES`, default 2: clock edges from operand latch to HI/LO capture. Legal range is 1..15.
- `clock` in 1: rising-edge clock.
- `clear_n` in 1: asynchronous active-low reset.
- `start` in 1: request a multiply. Sampled only in IDLE or DONE.
- `is_unsigned` in 1: unsigned multiply request. Present only when `MUL_UNSIGNED_EN` is defined.
- `op_a` in 32: multiplicand.
- `op_b` in 32: multiplier.
- `hi_load` in 1: write `load_data` to HI.
- `lo_load` in 1: write `load_data` to LO.
- `load_data` in 32: direct-load value.
- `busy` out 1: multiply in progress.
- `done` out 1: one-cycle pulse after HI/LO capture.
- `hi` out 32: HI register, product bits [63:32].
- `lo` out 32: LO register, product bits [31:0].

## Operation
- Clocking: one clock. Reset is asynchronous and active-low.
- States:
  - IDLE: waiting for `start`.
  - SETTLE: product settling.
  - DONE: result captured.
- IDLE or DONE with `start`=1:
  - Latch `op_a`/`op_b` (and `is_unsigned`) into operand registers.
  - Load `cnt` with SETTLE_CYCLES-1.
  - Go to SETTLE.
- IDLE or DONE without `start`: DONE returns to IDLE; IDLE stays in IDLE.
- SETTLE with `cnt`≠0: decrement `cnt`.
- SETTLE with `cnt`=0: capture `hi`←P[63:32] and `lo`←P[31:0], then go to DONE.
- Operand source: `booth_mul` is fed only from the operand registers, never from the live inputs. Changing `op_a`/`op_b` during SETTLE has no effect.
- Outputs:
  - `busy` = (state==SETTLE).
  - `done` = (state==DONE).
  - Both are decoded from registered state.
- Arithmetic: signed product is P = op_a × op_b (two's complement), 64-bit, exact, no overflow.
- `start` during SETTLE: ignored, not queued.
- `hi_load`/`lo_load`:
  - In IDLE or DONE, written on the edge.
  - During SETTLE, ignored, except that the capture edge overrides them.
  - If `start` and `hi_load`/`lo_load` are asserted on the same edge in IDLE, both take effect; the later capture overwrites HI/LO.
- Reset, including mid-SETTLE: state←IDLE, `cnt`←0, operand registers←0, `hi`←0, `lo`←0, `busy`=0, `done`=0. No capture occurs.

## Timing
- `start` sampled at edge k. `busy`=1 from k through edge k+SETTLE_CYCLES. HI/LO update at edge k+SETTLE_CYCLES. `done`=1 for the following single cycle.
- With SETTLE_CYCLES=2: start at edge 0, capture at edge 2, `done` high between edges 2 and 3.
- Back-to-back: `start` during DONE begins the next multiply on that edge. Throughput is one multiply per SETTLE_CYCLES+1 cycles.
- The path from the operand registers through `booth_mul` to HI/LO is a multicycle path of SETTLE_CYCLES. It is constrained as such in timing constraints.
- `hi`/`lo` are register outputs with no combinational path from any input.

## Configuration
- `MUL_UNSIGNED_EN` defined:
  - `is_unsigned` port exists and is latched with the operands.
  - When the latched value is 1, the result is P_u = P_s + ((a[31]?b:0) + (b[31]?a:0))<<32, modulo 2^64. This is the exact unsigned 64-bit product.
- `MUL_UNSIGNED_EN` undefined:
  - No `is_unsigned` port and no correction adders.
  - All multiplies are signed.

## Structure
- Package `mul_pkg`:
  - State encoding (IDLE=0, SETTLE=1, DONE=2).
  - WORD_W=32 and PROD_W=64.
  - CNT_W=4.
- Sub-module: one instance of the existing `booth_mul`. The unsigned correction, FSM, counter and HI/LO registers are inline in `mul_hilo_unit`.

## Test plan
1. Reset and assert `clear_n`=0 mid-SETTLE → `hi`=`lo`=0, `busy`=`done`=0, state IDLE. No capture on a later edge.
2. Signed, SETTLE_CYCLES=2: `op_a`=0xFFFFFFFD (−3), `op_b`=7 → at edge 2, `hi`=0xFFFFFFFF and `lo`=0xFFFFFFEB. `done` high exactly one cycle.
3. Extremes:
   - 0x80000000×0x80000000 → `hi`=0x40000000, `lo`=0.
   - 0x7FFFFFFF×0x80000000 → `hi`=0xC0000000, `lo`=0x80000000.
4. Handshake:
   - `start` pulsed during SETTLE → ignored, single `done`.
   - Operands changed during SETTLE → result from the original operands.
   - `start` in DONE → new multiply, `busy` reasserts the next cycle.
5. Loads:
   - `lo_load`=1, `load_data`=0x1234 in IDLE → `lo`=0x1234.
   - `hi_load` on the capture edge → `hi` holds the product, not `load_data`.
6. With `MUL_UNSIGNED_EN`: 0xFFFFFFFF×0xFFFFFFFF
   - `is_unsigned`=1 → `hi`=0xFFFFFFFE, `lo`=0x00000001.
   - `is_unsigned`=0 → `hi`=0, `lo`=1.

Source files
------------

// File: rtl/mul_pkg.sv
// mul_pkg: shared types and widths for the HI/LO multiply unit.
//   state_t : FSM encoding (IDLE=0, SETTLE=1, DONE=2)
//   WORD_W  : operand / HI / LO width
//   PROD_W  : full product width
//   CNT_W   : settle counter width (covers SETTLE_CYCLES 1..15)
package mul_pkg;

  localparam int WORD_W = 32;
  localparam int PROD_W = 64;
  localparam int CNT_W  = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

endpackage

// File: rtl/booth_mul.sv
// booth_mul: combinational 32x32 signed radix-4 Booth multiplier.
// Ports:
//   a : multiplicand (two's complement)
//   b : multiplier (two's complement)
//   p : exact 64-bit signed product
// The multiplier is scanned in 16 overlapping 3-bit groups; each group
// selects one of {0, +a, +2a, -a, -2a}, weighted by 4^i. All arithmetic is
// done at product width so the sum is exact modulo 2^64.
module booth_mul
  import mul_pkg::*;
(
  input  logic [WORD_W-1:0] a,
  input  logic [WORD_W-1:0] b,
  output logic [PROD_W-1:0] p
);

  logic [PROD_W-1:0] a_ext;
  logic [PROD_W-1:0] pp;
  logic [PROD_W-1:0] acc;
  logic [WORD_W:0]   b_ext;
  logic [2:0]        grp;

  always_comb begin
    a_ext = {{(PROD_W-WORD_W){a[WORD_W-1]}}, a};
    // Implicit b[-1] = 0 below the LSB.
    b_ext = {b, 1'b0};
    acc   = '0;
    pp    = '0;
    grp   = '0;
    for (int i = 0; i < WORD_W/2; i++) begin
      grp = b_ext[2*i +: 3];
      case (grp)
        3'b001, 3'b010: pp = a_ext;
        3'b011:         pp = a_ext << 1;
        3'b100:         pp = -(a_ext << 1);
        3'b101, 3'b110: pp = -a_ext;
        default:        pp = '0;
      endcase
      acc = acc + (pp << (2*i));
    end
    p = acc;
  end

endmodule

// File: rtl/mul_hilo_unit.sv
// mul_hilo_unit: multicycle wrapper around booth_mul owning the HI/LO pair.
// Optional feature macro: MUL_UNSIGNED_EN (adds is_unsigned and the
// unsigned correction adders; without it every multiply is signed).
// Ports:
//   clock       : rising-edge clock
//   clear_n     : asynchronous active-low reset
//   start       : multiply request, sampled only in IDLE or DONE
//   is_unsigned : unsigned multiply (MUL_UNSIGNED_EN builds only)
//   op_a, op_b  : operands, latched on the start edge
//   hi_load     : write load_data to HI (IDLE/DONE only)
//   lo_load     : write load_data to LO (IDLE/DONE only)
//   load_data   : direct-load value
//   busy        : multiply in progress (state == SETTLE)
//   done        : one-cycle pulse after HI/LO capture (state == DONE)
//   hi, lo      : HI/LO registers
//   state_dbg   : current FSM state, for observation only
//
// Handshake: start is a plain request with no ready; it is accepted on any
// edge where busy=0 and dropped (not queued) while busy=1. done is a status
// pulse, not a valid awaiting acknowledgement.
//
// The operand registers -> booth_mul -> HI/LO path is a multicycle path of
// SETTLE_CYCLES edges; legal SETTLE_CYCLES is 1..15.
module mul_hilo_unit
  import mul_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic              clock,
  input  logic              clear_n,
  input  logic              start,
`ifdef MUL_UNSIGNED_EN
  input  logic              is_unsigned,
`endif
  input  logic [WORD_W-1:0] op_a,
  input  logic [WORD_W-1:0] op_b,
  input  logic              hi_load,
  input  logic              lo_load,
  input  logic [WORD_W-1:0] load_data,
  output logic              busy,
  output logic              done,
  output logic [WORD_W-1:0] hi,
  output logic [WORD_W-1:0] lo,
  output logic [1:0]        state_dbg
);

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic [WORD_W-1:0] opa_q;
  logic [WORD_W-1:0] opb_q;
  logic [PROD_W-1:0] prod_s;
  logic [PROD_W-1:0] prod;

  // The multiplier only ever sees the latched operands, so the live inputs
  // may change freely while the product settles.
  booth_mul u_booth (
    .a (opa_q),
    .b (opb_q),
    .p (prod_s)
  );

`ifdef MUL_UNSIGNED_EN
  logic              uns_q;
  logic [WORD_W-1:0] corr;

  // Reinterpreting a set sign bit as +2^31 adds b<<32 (resp. a<<32) to the
  // signed product; only the low word of the correction survives mod 2^64.
  always_comb begin
    corr = (opa_q[WORD_W-1] ? opb_q : '0) + (opb_q[WORD_W-1] ? opa_q : '0);
    prod = uns_q ? (prod_s + {corr, {WORD_W{1'b0}}}) : prod_s;
  end
`else
  assign prod = prod_s;
`endif

  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      state <= ST_IDLE;
      cnt   <= '0;
      opa_q <= '0;
      opb_q <= '0;
`ifdef MUL_UNSIGNED_EN
      uns_q <= 1'b0;
`endif
      hi    <= '0;
      lo    <= '0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          // Direct loads land now; a multiply started on the same edge
          // overwrites them later at capture.
          if (hi_load) hi <= load_data;
          if (lo_load) lo <= load_data;
          if (start) begin
            opa_q <= op_a;
            opb_q <= op_b;
`ifdef MUL_UNSIGNED_EN
            uns_q <= is_unsigned;
`endif
            cnt   <= CNT_W'(SETTLE_CYCLES - 1);
            state <= ST_SETTLE;
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_SETTLE: begin
          // Loads are ignored here; capture owns HI/LO on the final edge.
          if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
          end else begin
            hi    <= prod[PROD_W-1:WORD_W];
            lo    <= prod[WORD_W-1:0];
            state <= ST_DONE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign busy      = (state == ST_SETTLE);
  assign done      = (state == ST_DONE);
  assign state_dbg = state;

endmodule

// File: tb/tb_mul_hilo_unit.sv
// tb_mul_hilo_unit: directed + random self-checking bench for mul_hilo_unit.
// Expected products come from a behavioural 64-bit multiply model and are
// queued when a multiply is started, then popped when done is observed.
module tb_mul_hilo_unit;

  localparam int SC = 2;

  logic        clock = 1'b0;
  logic        clear_n = 1'b0;
  logic        start = 1'b0;
`ifdef MUL_UNSIGNED_EN
  logic        is_unsigned = 1'b0;
`endif
  logic [31:0] op_a = '0;
  logic [31:0] op_b = '0;
  logic        hi_load = 1'b0;
  logic        lo_load = 1'b0;
  logic [31:0] load_data = '0;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;
  logic [1:0]  state_dbg;

  int checks = 0;
  int failures = 0;
  logic [63:0] exp_q[$];

  // ---------------- clock / reset ----------------
  always #5 clock = ~clock;

  mul_hilo_unit #(.SETTLE_CYCLES(SC)) dut (
    .clock       (clock),
    .clear_n     (clear_n),
    .start       (start),
`ifdef MUL_UNSIGNED_EN
    .is_unsigned (is_unsigned),
`endif
    .op_a        (op_a),
    .op_b        (op_b),
    .hi_load     (hi_load),
    .lo_load     (lo_load),
    .load_data   (load_data),
    .busy        (busy),
    .done        (done),
    .hi          (hi),
    .lo          (lo),
    .state_dbg   (state_dbg)
  );

  // ---------------- model ----------------
  function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b,
                                        input logic uns);
    logic signed [63:0] sa;
    logic signed [63:0] sb;
    sa = $signed(a);
    sb = $signed(b);
    if (uns) return {32'b0, a} * {32'b0, b};
    return sa * sb;
  endfunction

  // ---------------- checker ----------------
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Drives a start request at the current time (caller positions on a negedge).
  task automatic start_mul(input logic [31:0] a, input logic [31:0] b,
                           input logic uns, input bit push);
    op_a  = a;
    op_b  = b;
`ifdef MUL_UNSIGNED_EN
    is_unsigned = uns;
`endif
    start = 1'b1;
    if (push) exp_q.push_back(model(a, b, uns));
  endtask

  // Waits (bounded) for done, sampling on negedges; n = negedges waited.
  task automatic wait_done(output int n);
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (!done && n < 40);
    check("done_seen", {63'b0, done}, 64'd1);
  endtask

  task automatic check_result(input string tag);
    logic [63:0] exp;
    exp = (exp_q.size() > 0) ? exp_q.pop_front() : 64'bx;
    check(tag, {hi, lo}, exp);
  endtask

  // Plain multiply with full handshake timing checks.
  task automatic run_mul(input logic [31:0] a, input logic [31:0] b,
                         input logic uns, input string tag);
    int n;
    @(negedge clock);
    start_mul(a, b, uns, 1'b1);
    @(negedge clock);
    start = 1'b0;
    check({tag, "_busy"}, {62'b0, busy, done}, 64'b10);
    wait_done(n);
    check({tag, "_latency"}, 64'(n), 64'(SC));
    check_result(tag);
    @(negedge clock);
    check({tag, "_done_pulse"}, {60'b0, busy, done, state_dbg}, 64'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n;
    logic [31:0] ra;
    logic [31:0] rb;

    // Reset state
    #12;
    check("reset_hilo", {hi, lo}, 64'd0);
    check("reset_flags", {60'b0, busy, done, state_dbg}, 64'd0);
    @(negedge clock);
    clear_n = 1'b1;

    // Direct loads in IDLE
    @(negedge clock);
    lo_load = 1'b1;
    load_data = 32'h0000_1234;
    @(negedge clock);
    lo_load = 1'b0;
    check("lo_load", {hi, lo}, 64'h0000_0000_0000_1234);
    hi_load = 1'b1;
    load_data = 32'h0000_CAFE;
    @(negedge clock);
    hi_load = 1'b0;
    check("hi_load", {hi, lo}, 64'h0000_CAFE_0000_1234);

    // Directed signed products
    run_mul(32'hFFFF_FFFD, 32'd7, 1'b0, "neg3x7");
    check("neg3x7_lit", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFEB);
    run_mul(32'h8000_0000, 32'h8000_0000, 1'b0, "minxmin");
    check("minxmin_lit", {hi, lo}, 64'h4000_0000_0000_0000);
    run_mul(32'h7FFF_FFFF, 32'h8000_0000, 1'b0, "maxxmin");
    check("maxxmin_lit", {hi, lo}, 64'hC000_0000_8000_0000);
    run_mul(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, "m1xm1");
    check("m1xm1_lit", {hi, lo}, 64'h0000_0000_0000_0001);

    // Random signed products
    for (int i = 0; i < 6; i++) begin
      ra = $urandom;
      rb = $urandom_range(0, 3) == 0 ? 32'($urandom_range(0, 15)) : $urandom;
      run_mul(ra, rb, 1'b0, "rand");
    end

    // start pulsed and operands changed during SETTLE
    @(negedge clock);
    start_mul(32'd12345, 32'hFFFF_FF00, 1'b0, 1'b1);
    @(negedge clock);
    check("settle_busy", {62'b0, busy, done}, 64'b10);
    start = 1'b1;
    op_a  = $urandom;
    op_b  = $urandom;
    @(negedge clock);
    start = 1'b0;
    wait_done(n);
    check_result("settle_ignore");
    @(negedge clock);
    check("no_queued_1", {62'b0, busy, done}, 64'd0);
    @(negedge clock);
    check("no_queued_2", {62'b0, busy, done}, 64'd0);

    // hi_load held across SETTLE including the capture edge
    @(negedge clock);
    start_mul(32'd1000, 32'd3000, 1'b0, 1'b1);
    @(negedge clock);
    start = 1'b0;
    hi_load = 1'b1;
    load_data = 32'hDEAD_BEEF;
    wait_done(n);
    hi_load = 1'b0;
    check_result("hi_load_capture");

    // start and lo_load on the same IDLE edge
    @(negedge clock);
    @(negedge clock);
    start_mul(32'hFFFF_0000, 32'h0001_0003, 1'b0, 1'b1);
    lo_load = 1'b1;
    load_data = 32'h0000_55AA;
    @(negedge clock);
    start = 1'b0;
    lo_load = 1'b0;
    check("start_lo_load_lo", {32'b0, lo}, 64'h0000_55AA);
    wait_done(n);
    check_result("start_lo_load_cap");

    // Back-to-back: start issued while in DONE
    @(negedge clock);
    start_mul(32'd77, 32'd99, 1'b0, 1'b1);
    @(negedge clock);
    start = 1'b0;
    wait_done(n);
    check_result("b2b_first");
    start_mul(32'h8000_0001, 32'd5, 1'b0, 1'b1);
    @(negedge clock);
    start = 1'b0;
    check("b2b_busy", {60'b0, busy, done, state_dbg}, {60'b0, 2'b10, 2'd1});
    wait_done(n);
    check("b2b_latency", 64'(n), 64'(SC));
    check_result("b2b_second");

`ifdef MUL_UNSIGNED_EN
    run_mul(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, "u_m1xm1");
    check("u_m1xm1_lit", {hi, lo}, 64'hFFFF_FFFE_0000_0001);
    run_mul(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, "s_m1xm1");
    check("s_m1xm1_lit", {hi, lo}, 64'h0000_0000_0000_0001);
    for (int i = 0; i < 4; i++) begin
      run_mul($urandom, $urandom, 1'b1, "u_rand");
    end
`endif

    // Reset asserted mid-SETTLE (HI/LO non-zero beforehand)
    @(negedge clock);
    start_mul(32'd6, 32'd7, 1'b0, 1'b0);
    @(negedge clock);
    start = 1'b0;
    check("pre_reset_busy", {62'b0, busy, done}, 64'b10);
    #2 clear_n = 1'b0;
    #1;
    check("midreset_hilo", {hi, lo}, 64'd0);
    check("midreset_flags", {60'b0, busy, done, state_dbg}, 64'd0);
    @(negedge clock);
    clear_n = 1'b1;
    for (int i = 0; i < SC + 2; i++) begin
      @(negedge clock);
      check("no_capture_after_reset", {busy, done, state_dbg, hi, lo}, 68'd0);
    end

    check("queue_empty", 64'(exp_q.size()), 64'd0);

    // ---------------- report ----------------
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
